// File: rtl/mem_access_stage.sv
// MEM pipeline stage: holds the EX result in stage register S and runs a stall-based
// handshake to the data memory. Define MEM_TIMEOUT_EN to add a TIMEOUT_CYCLES WAIT watchdog.
//
// state | meaning
// IDLE  | S holds an op; non-memory ops pass through, aligned memory ops start a request
// WAIT  | request held on the memory port, pipeline stalled until memReady (or timeout)
// RESP  | response presented from D, pipeline released
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite,
    input  logic [1:0]  MemToReg,
    input  logic [4:0]  RegDst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] aluResult,
    input  logic [31:0] writeData,
    input  logic [31:0] adderPcOut,
    input  logic        inValid,
    output logic        stall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic [31:0] memRData,
    input  logic        memReady,
    output logic        RegWriteMEM,
    output logic [1:0]  MemToRegMEM,
    output logic [4:0]  RegDstMEM,
    output logic [31:0] memoryDataMEM,
    output logic [31:0] aluResultMEM,
    output logic [31:0] adderPcOutMEM,
    output logic        alignErr,
    output logic        memErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT       state;
    stateT       stateNext;

    logic        sValid;
    logic        sRegWrite;
    logic [1:0]  sMemToReg;
    logic [4:0]  sRegDst;
    logic        sMemRead;
    logic        sMemWrite;
    logic [31:0] sAlu;
    logic [31:0] sWData;
    logic [31:0] sPc;
    logic [31:0] dataReg;

    logic        memOp;
    logic        aligned;
    logic        timeoutHit;
    logic        timedOut;

    assign memOp   = sValid & (sMemRead | sMemWrite);
    assign aligned = (sAlu[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sValid    <= 1'b0;
            sRegWrite <= 1'b0;
            sMemToReg <= '0;
            sRegDst   <= '0;
            sMemRead  <= 1'b0;
            sMemWrite <= 1'b0;
            sAlu      <= '0;
            sWData    <= '0;
            sPc       <= '0;
        end else if (!stall) begin
            sValid    <= inValid;
            sRegWrite <= RegWrite;
            sMemToReg <= MemToReg;
            sRegDst   <= RegDst;
            sMemRead  <= MemRead;
            sMemWrite <= MemWrite;
            sAlu      <= aluResult;
            sWData    <= writeData;
            sPc       <= adderPcOut;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CntW = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;

    logic [CntW-1:0] waitCnt;

    // waitCnt counts completed WAIT cycles, so the last allowed cycle sees TIMEOUT_CYCLES-1
    assign timeoutHit = (state == WAIT) && !memReady &&
                        (waitCnt == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt  <= '0;
            timedOut <= 1'b0;
        end else begin
            if (state == WAIT) begin
                waitCnt  <= waitCnt + 1'b1;
                timedOut <= timeoutHit;
            end else begin
                waitCnt  <= '0;
            end
        end
    end

    assign memErr = (state == RESP) & timedOut;
`else
    assign timeoutHit = 1'b0;
    assign timedOut   = 1'b0;
    assign memErr     = 1'b0;
`endif

    // A combined read+write is a write, so its response data is forced to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataReg <= '0;
        end else if (state == WAIT) begin
            if (memReady) begin
                dataReg <= sMemWrite ? 32'h0 : memRData;
            end else if (timeoutHit) begin
                dataReg <= 32'hDEADBEEF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext     = state;
        stall         = 1'b0;
        memReq        = 1'b0;
        alignErr      = 1'b0;
        RegWriteMEM   = 1'b0;
        memoryDataMEM = '0;
        case (state)
            IDLE: begin
                if (memOp) begin
                    if (aligned) begin
                        stall     = 1'b1;
                        stateNext = WAIT;
                    end else begin
                        alignErr  = 1'b1;
                    end
                end else begin
                    RegWriteMEM = sValid & sRegWrite;
                end
            end
            WAIT: begin
                stall  = 1'b1;
                memReq = 1'b1;
                if (memReady || timeoutHit) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                RegWriteMEM   = sValid & sRegWrite & ~timedOut;
                memoryDataMEM = dataReg;
                stateNext     = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign memWe    = memReq & sMemWrite;
    assign memAddr  = memReq ? sAlu : 32'h0;
    assign memWData = memReq ? sWData : 32'h0;

    assign MemToRegMEM   = sMemToReg;
    assign RegDstMEM     = sRegDst;
    assign aluResultMEM  = sAlu;
    assign adderPcOutMEM = sPc;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a randomized op stream
// checked against a per-op outcome model. Build with MEM_TIMEOUT_EN to cover the watchdog.
module tb_mem_access_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 15;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        RegWrite;
    logic [1:0]  MemToReg;
    logic [4:0]  RegDst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] aluResult;
    logic [31:0] writeData;
    logic [31:0] adderPcOut;
    logic        inValid;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memReady;
    logic        RegWriteMEM;
    logic [1:0]  MemToRegMEM;
    logic [4:0]  RegDstMEM;
    logic [31:0] memoryDataMEM;
    logic [31:0] aluResultMEM;
    logic [31:0] adderPcOutMEM;
    logic        alignErr;
    logic        memErr;

    int nChecks = 0;
    int nPass   = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .aluResult(aluResult), .writeData(writeData), .adderPcOut(adderPcOut),
        .inValid(inValid), .stall(stall),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData), .memReady(memReady),
        .RegWriteMEM(RegWriteMEM), .MemToRegMEM(MemToRegMEM), .RegDstMEM(RegDstMEM),
        .memoryDataMEM(memoryDataMEM), .aluResultMEM(aluResultMEM),
        .adderPcOutMEM(adderPcOutMEM), .alignErr(alignErr), .memErr(memErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", nPass, nChecks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic v, input logic rw, input logic [1:0] mtr,
                            input logic [4:0] rd, input logic mr, input logic mw,
                            input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc);
        inValid    = v;
        RegWrite   = rw;
        MemToReg   = mtr;
        RegDst     = rd;
        MemRead    = mr;
        MemWrite   = mw;
        aluResult  = alu;
        writeData  = wd;
        adderPcOut = pc;
    endtask

    task automatic drive_junk();
        drive_op(1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom), 1'($urandom),
                 1'($urandom), $urandom, $urandom, $urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        memReady = 1'b1;
        memRData = $urandom;
        drive_junk();
        repeat (3) tick();
        nChecks++;
        if ({stall, memReq, alignErr, memErr, RegWriteMEM, MemToRegMEM, RegDstMEM} !== 11'h0) begin
            $display("FAIL reset_ctrl: got %h expected 0",
                     {stall, memReq, alignErr, memErr, RegWriteMEM, MemToRegMEM, RegDstMEM});
        end else nPass++;
        nChecks++;
        if ({memoryDataMEM, aluResultMEM, adderPcOutMEM} !== 96'h0) begin
            $display("FAIL reset_data: got %h expected 0",
                     {memoryDataMEM, aluResultMEM, adderPcOutMEM});
        end else nPass++;
        memReady = 1'b0;
        drive_op(1'b1, 1'b1, 2'd2, 5'd9, 1'b0, 1'b0, 32'h1234_5670, 32'h0, 32'h0000_0200);
        rst = 1'b1;
        tick();
        nChecks++;
        if ({stall, RegWriteMEM, MemToRegMEM, RegDstMEM, aluResultMEM, adderPcOutMEM} !==
            {1'b0, 1'b1, 2'd2, 5'd9, 32'h1234_5670, 32'h0000_0200}) begin
            $display("FAIL reset_first_load: got %h expected %h",
                     {stall, RegWriteMEM, MemToRegMEM, RegDstMEM, aluResultMEM, adderPcOutMEM},
                     {1'b0, 1'b1, 2'd2, 5'd9, 32'h1234_5670, 32'h0000_0200});
        end else nPass++;
    endtask

    task automatic test_alu();
        drive_op(1'b1, 1'b1, 2'd0, 5'd7, 1'b0, 1'b0, 32'h10, 32'hAAAA_5555, 32'h104);
        tick();
        nChecks++;
        if ({stall, memReq, alignErr, RegWriteMEM} !== 4'b0001) begin
            $display("FAIL alu_ctrl: got %b expected 0001", {stall, memReq, alignErr, RegWriteMEM});
        end else nPass++;
        nChecks++;
        if ({aluResultMEM, RegDstMEM, adderPcOutMEM} !== {32'h10, 5'd7, 32'h104}) begin
            $display("FAIL alu_data: got %h expected %h",
                     {aluResultMEM, RegDstMEM, adderPcOutMEM}, {32'h10, 5'd7, 32'h104});
        end else nPass++;
    endtask

    task automatic test_load();
        int stallCnt;
        drive_op(1'b1, 1'b1, 2'd1, 5'd3, 1'b1, 1'b0, 32'h40, 32'h0, 32'h300);
        memReady = 1'b0;
        memRData = 32'hCAFEF00D;
        tick();
        stallCnt = int'(stall);
        memReady = 1'b1;
        drive_junk();
        tick();
        stallCnt += int'(stall);
        nChecks++;
        if ({memReq, memWe, memAddr} !== {1'b1, 1'b0, 32'h40}) begin
            $display("FAIL load_req: got %h expected %h", {memReq, memWe, memAddr}, {1'b1, 1'b0, 32'h40});
        end else nPass++;
        drive_junk();
        tick();
        stallCnt += int'(stall);
        memReady = 1'b0;
        nChecks++;
        if (stallCnt !== 2) begin
            $display("FAIL load_stall_cycles: got %0d expected 2", stallCnt);
        end else nPass++;
        nChecks++;
        if ({memReq, RegWriteMEM, memoryDataMEM} !== {1'b0, 1'b1, 32'hCAFEF00D}) begin
            $display("FAIL load_resp: got %h expected %h",
                     {memReq, RegWriteMEM, memoryDataMEM}, {1'b0, 1'b1, 32'hCAFEF00D});
        end else nPass++;
    endtask

    task automatic test_store();
        int stallCnt;
        drive_op(1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 32'h80, 32'h12345678, 32'h400);
        memReady = 1'b0;
        memRData = 32'hFFFF_FFFF;
        tick();
        stallCnt = int'(stall);
        drive_junk();
        for (int k = 1; k <= 3; k++) begin
            tick();
            stallCnt += int'(stall);
            nChecks++;
            if ({memReq, memWe, memAddr, memWData, RegWriteMEM} !==
                {1'b1, 1'b1, 32'h80, 32'h12345678, 1'b0}) begin
                $display("FAIL store_wait%0d: got %h expected %h", k,
                         {memReq, memWe, memAddr, memWData, RegWriteMEM},
                         {1'b1, 1'b1, 32'h80, 32'h12345678, 1'b0});
            end else nPass++;
            memReady = (k == 3);
            drive_junk();
        end
        tick();
        stallCnt += int'(stall);
        memReady = 1'b0;
        nChecks++;
        if (stallCnt !== 4) begin
            $display("FAIL store_stall_cycles: got %0d expected 4", stallCnt);
        end else nPass++;
        nChecks++;
        if ({memReq, RegWriteMEM, memoryDataMEM} !== {1'b0, 1'b0, 32'h0}) begin
            $display("FAIL store_resp: got %h expected %h",
                     {memReq, RegWriteMEM, memoryDataMEM}, {1'b0, 1'b0, 32'h0});
        end else nPass++;
    endtask

    task automatic test_misaligned();
        drive_op(1'b1, 1'b1, 2'd1, 5'd4, 1'b1, 1'b0, 32'h42, 32'h0, 32'h500);
        memReady = 1'b0;
        tick();
        nChecks++;
        if ({alignErr, memReq, RegWriteMEM, stall} !== 4'b1000) begin
            $display("FAIL misaligned: got %b expected 1000", {alignErr, memReq, RegWriteMEM, stall});
        end else nPass++;
        drive_op(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        nChecks++;
        if ({alignErr, memReq, stall} !== 3'b000) begin
            $display("FAIL misaligned_after: got %b expected 000", {alignErr, memReq, stall});
        end else nPass++;
    endtask

    task automatic test_reset_in_wait();
        drive_op(1'b1, 1'b1, 2'd1, 5'd5, 1'b1, 1'b0, 32'h100, 32'h0, 32'h600);
        memReady = 1'b0;
        tick();
        tick();
        tick();
        nChecks++;
        if ({memReq, stall} !== 2'b11) begin
            $display("FAIL rstwait_pre: got %b expected 11", {memReq, stall});
        end else nPass++;
        #2;
        rst = 1'b0;
        #1;
        nChecks++;
        if ({memReq, stall} !== 2'b00) begin
            $display("FAIL rstwait_async: got %b expected 00", {memReq, stall});
        end else nPass++;
        drive_op(1'b1, 1'b1, 2'd0, 5'd6, 1'b0, 1'b0, 32'h55, 32'h0, 32'h700);
        #2;
        rst = 1'b1;
        tick();
        nChecks++;
        if ({stall, memReq, RegWriteMEM, aluResultMEM} !== {1'b0, 1'b0, 1'b1, 32'h55}) begin
            $display("FAIL rstwait_alu: got %h expected %h",
                     {stall, memReq, RegWriteMEM, aluResultMEM}, {1'b0, 1'b0, 1'b1, 32'h55});
        end else nPass++;
        drive_op(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        nChecks++;
        if ({memReq, stall} !== 2'b00) begin
            $display("FAIL rstwait_no_replay: got %b expected 00", {memReq, stall});
        end else nPass++;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int waitCycles;
        drive_op(1'b1, 1'b1, 2'd1, 5'd8, 1'b1, 1'b0, 32'h200, 32'h0, 32'h800);
        memReady = 1'b0;
        tick();
        waitCycles = 0;
        for (int c = 0; c < 30; c++) begin
            drive_junk();
            tick();
            if (!memReq) break;
            waitCycles++;
        end
        nChecks++;
        if (waitCycles !== TO) begin
            $display("FAIL timeout_wait_cycles: got %0d expected %0d", waitCycles, TO);
        end else nPass++;
        nChecks++;
        if ({memErr, RegWriteMEM, stall, memoryDataMEM} !== {1'b1, 1'b0, 1'b0, 32'hDEADBEEF}) begin
            $display("FAIL timeout_resp: got %h expected %h",
                     {memErr, RegWriteMEM, stall, memoryDataMEM}, {1'b1, 1'b0, 1'b0, 32'hDEADBEEF});
        end else nPass++;
        drive_op(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        nChecks++;
        if ({memErr, memReq, stall} !== 3'b000) begin
            $display("FAIL timeout_idle: got %b expected 000", {memErr, memReq, stall});
        end else nPass++;
    endtask
`endif

    // Each op is judged by its outcome class: pass-through, misaligned, or a memory
    // transaction whose length is set by the chosen ready latency (capped by the watchdog).
    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            int          kind;
            int          lat;
            int          waits;
            bit          isMem;
            bit          timed;
            logic        v, rw, mr, mw;
            logic [1:0]  mtr;
            logic [4:0]  rd;
            logic [31:0] alu, wd, pc, rdata, expData;
            kind = $urandom_range(0, 5);
            rw   = 1'($urandom);
            mtr  = 2'($urandom);
            rd   = 5'($urandom);
            wd   = $urandom;
            pc   = $urandom;
            alu  = $urandom & 32'hFFFF_FFFC;
            v    = 1'b1;
            mr   = 1'b0;
            mw   = 1'b0;
            case (kind)
                0: begin v = 1'b0; mr = 1'($urandom); mw = 1'($urandom); alu = $urandom; end
                1: alu = $urandom;
                2: mr = 1'b1;
                3: mw = 1'b1;
                4: begin mr = 1'b1; mw = 1'b1; end
                default: begin
                    mr  = 1'($urandom);
                    mw  = ~mr;
                    alu = alu | 32'($urandom_range(1, 3));
                end
            endcase
            lat   = ($urandom_range(0, 7) == 0) ? $urandom_range(7, 20) : $urandom_range(1, 6);
            isMem = v && (mr || mw);
            timed = TO_EN && (lat > TO);
            waits = timed ? TO : lat;
            rdata = 32'h0;

            drive_op(v, rw, mtr, rd, mr, mw, alu, wd, pc);
            memReady = 1'($urandom);
            memRData = $urandom;
            tick();
            nChecks++;
            if ({MemToRegMEM, RegDstMEM, aluResultMEM, adderPcOutMEM} !== {mtr, rd, alu, pc}) begin
                $display("FAIL rand_pass op%0d: got %h expected %h", n,
                         {MemToRegMEM, RegDstMEM, aluResultMEM, adderPcOutMEM}, {mtr, rd, alu, pc});
            end else nPass++;

            if (!isMem) begin
                nChecks++;
                if ({stall, memReq, alignErr, memErr, RegWriteMEM} !== {4'b0000, v & rw}) begin
                    $display("FAIL rand_nonmem op%0d: got %b expected %b", n,
                             {stall, memReq, alignErr, memErr, RegWriteMEM}, {4'b0000, v & rw});
                end else nPass++;
            end else if (alu[1:0] != 2'b00) begin
                nChecks++;
                if ({stall, memReq, alignErr, memErr, RegWriteMEM} !== 5'b00100) begin
                    $display("FAIL rand_misaligned op%0d: got %b expected 00100", n,
                             {stall, memReq, alignErr, memErr, RegWriteMEM});
                end else nPass++;
            end else begin
                nChecks++;
                if ({stall, memReq, alignErr, memErr, RegWriteMEM} !== 5'b10000) begin
                    $display("FAIL rand_issue op%0d: got %b expected 10000", n,
                             {stall, memReq, alignErr, memErr, RegWriteMEM});
                end else nPass++;
                memReady = 1'($urandom);
                drive_junk();
                for (int k = 1; k <= waits; k++) begin
                    tick();
                    nChecks++;
                    if ({stall, memReq, memWe, memAddr, memWData, RegWriteMEM, memErr} !==
                        {1'b1, 1'b1, mw, alu, wd, 1'b0, 1'b0}) begin
                        $display("FAIL rand_wait op%0d cyc%0d: got %h expected %h", n, k,
                                 {stall, memReq, memWe, memAddr, memWData, RegWriteMEM, memErr},
                                 {1'b1, 1'b1, mw, alu, wd, 1'b0, 1'b0});
                    end else nPass++;
                    memReady = (k == lat);
                    memRData = $urandom;
                    if (k == lat) rdata = memRData;
                    drive_junk();
                end
                tick();
                memReady = 1'b0;
                expData = timed ? 32'hDEADBEEF : (mw ? 32'h0 : rdata);
                nChecks++;
                if ({stall, memReq, alignErr, memErr, RegWriteMEM, memoryDataMEM} !==
                    {1'b0, 1'b0, 1'b0, timed, rw & ~timed, expData}) begin
                    $display("FAIL rand_resp op%0d: got %h expected %h", n,
                             {stall, memReq, alignErr, memErr, RegWriteMEM, memoryDataMEM},
                             {1'b0, 1'b0, 1'b0, timed, rw & ~timed, expData});
                end else nPass++;
                nChecks++;
                if ({MemToRegMEM, RegDstMEM, aluResultMEM, adderPcOutMEM} !== {mtr, rd, alu, pc}) begin
                    $display("FAIL rand_hold op%0d: got %h expected %h", n,
                             {MemToRegMEM, RegDstMEM, aluResultMEM, adderPcOutMEM}, {mtr, rd, alu, pc});
                end else nPass++;
            end
        end
        memReady = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        memReady = 1'b0;
        memRData = 32'h0;
        drive_op(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_reset_in_wait();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, is the maximum number of WAIT cycles before abort; it is used only when MEM_TIMEOUT_EN is defined.
REQ-002 Port clk  input  1  is the single clock, and all state changes on posedge clk.
REQ-003 Port rst  input  1  is the asynchronous, active-low reset: low forces the reset state immediately, independent of clk.
REQ-004 Ports RegWrite input 1, MemToReg input 2, RegDst input 5, MemRead input 1 and MemWrite input 1 carry the EX-stage control.
REQ-005 Ports aluResult input 32, writeData input 32, adderPcOut input 32 and inValid input 1 carry the EX-stage data and the EX-stage valid.
REQ-006 Port stall  output  1  holds the EX stage and all upstream stages while high.
REQ-007 Ports memReq output 1, memWe output 1, memAddr output 32 and memWData output 32 form the data-memory request.
REQ-008 Ports memRData input 32 and memReady input 1 form the data-memory response; memReady=1 completes the current request.
REQ-009 Ports RegWriteMEM output 1, MemToRegMEM output 2, RegDstMEM output 5, memoryDataMEM output 32, aluResultMEM output 32 and adderPcOutMEM output 32 feed the MEM/WB register.
REQ-010 Port alignErr  output  1  is a one-cycle pulse on a misaligned memory op; port memErr  output  1  is a one-cycle pulse on a memory timeout.

Function
REQ-011 The stage register S (valid, all control, aluResult, writeData, adderPcOut) shall load its inputs on each posedge with stall=0 and shall hold its contents with stall=1.
REQ-012 A memory op is S.valid=1 and (S.MemRead=1 or S.MemWrite=1); S.MemRead=1 and S.MemWrite=1 together shall be treated as a write.
REQ-013 The FSM has three states: IDLE, WAIT and RESP; it is in IDLE after reset.
REQ-014 In IDLE, a non-memory op shall pass through with stall=0 and zero added latency, with outputs driven combinationally from S.
REQ-015 In IDLE, an aligned memory op (aluResult[1:0]=0) shall assert stall and move to WAIT on the next posedge.
REQ-016 In IDLE, a misaligned memory op shall raise alignErr for 1 cycle, issue no request, drive stall=0, force RegWriteMEM=0, and stay in IDLE.
REQ-017 In WAIT, memReq=1, memWe=S.MemWrite, memAddr=S.aluResult, memWData=S.writeData and stall=1; all four shall stay stable until memReady=1.
REQ-018 In WAIT with memReady=1, memRData shall be captured into the data register D and the FSM shall move to RESP; memReady on the first WAIT cycle shall be accepted.
REQ-019 In RESP, memReq=0, stall=0, and the outputs shall be presented with memoryDataMEM=D (D=0 for a write); the FSM shall then return to IDLE.
REQ-020 The minimum added latency of a memory op is 2 stall cycles (IDLE plus one WAIT).
REQ-021 memReady outside WAIT shall be ignored and shall change no state.
REQ-022 While the output is not valid (S.valid=0, or stall=1), RegWriteMEM shall be 0 so that the MEM/WB register receives a bubble.
REQ-023 The pass-through fields MemToRegMEM, RegDstMEM, aluResultMEM and adderPcOutMEM shall equal the corresponding S fields.
REQ-024 memReq shall be 0 in IDLE and RESP.

Reset
REQ-025 rst=0 shall asynchronously set state=IDLE, S.valid=0, all S fields and D to 0, and memReq, stall, alignErr, memErr and every *MEM output to 0.
REQ-026 Reset asserted in WAIT shall drop memReq in the same cycle; the in-flight op shall be discarded and not replayed.
REQ-027 After rst returns to 1, the first posedge shall load S normally.

Configuration
REQ-028 With MEM_TIMEOUT_EN defined, a 4-bit-or-wider counter shall clear on entry to WAIT and increment on each WAIT cycle.
REQ-029 With MEM_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES without memReady, the block shall drop memReq, pulse memErr, set D=32'hDEADBEEF and go to RESP with RegWriteMEM forced 0.
REQ-030 With MEM_TIMEOUT_EN undefined, WAIT shall persist indefinitely, memErr shall be tied to 0, and no counter logic shall exist.

Verification
REQ-031 ALU op (RegWrite=1, aluResult=32'h10, no mem op): stall stays 0 and the next cycle shows RegWriteMEM=1, aluResultMEM=32'h10.
REQ-032 Load from 32'h40 with memReady=1 on the first WAIT cycle and memRData=32'hCAFEF00D: stall is high for exactly 2 cycles, then the RESP cycle shows memoryDataMEM=32'hCAFEF00D.
REQ-033 Store of 32'h12345678 to 32'h80 with memReady delayed 3 cycles: memReq/memWe/memAddr/memWData stay stable for 3 cycles, RegWriteMEM=0 throughout, and stall is high for 4 cycles.
REQ-034 Load to 32'h42: alignErr pulses once, memReq never rises, RegWriteMEM=0 and stall=0.
REQ-035 Reset in the 2nd WAIT cycle: memReq and stall drop without waiting for a clock edge; after release, a following ALU op passes normally.
REQ-036 With MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4 and memReady held 0: memErr pulses after 4 WAIT cycles, memoryDataMEM=32'hDEADBEEF, RegWriteMEM=0, and the FSM returns to IDLE.
